multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  async active-high; forces state to FETCH.
REQ-004 opcode  input  6  instruction[31:26], valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 ALUop  output  3  to ALU control; 3'b111 = R-type (funct decides), else direct ALU code.
REQ-008 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  00 = B, 01 = const 1, 10 = sign-ext imm, 11 = zero-ext imm.
REQ-010 i_or_d, mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg  output  1 each  standard multicycle datapath controls.
REQ-011 pc_source  output  2  00 = ALU result, 01 = ALUOut (branch), 10 = jump target.
REQ-012 illegal_op  output  1  one-cycle pulse on unrecognised opcode.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 SHALL be a Moore FSM; outputs decode only from the state register, except the write enables gated by mem_ready and zero as stated below.
REQ-015 States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=000 (ADD). ir_write and pc_write SHALL be 1 only when mem_ready=1. The FSM stays in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-017 DECODE: alu_src_a=0, alu_src_b=10, ALUop=000. Next state by opcode: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 001000/001101 -> I_EXEC; 000100/000101 -> BRANCH; 000010 -> JUMP; any other -> FETCH with illegal_op=1 for this cycle.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=000. Goes to MEM_READ for 100011 and to MEM_WRITE for 101011.
REQ-019 MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
REQ-020 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-021 MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, ALUop=111; then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-023 I_EXEC: alu_src_a=1; addi uses alu_src_b=10 with ALUop=000; ori uses alu_src_b=11 with ALUop=001 (OR). Then I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, ALUop=101 (SUB), pc_source=01. pc_write=1 iff (opcode=000100 and zero=1) or (opcode=000101 and zero=0). Then FETCH.
REQ-025 JUMP: pc_source=10, pc_write=1; then FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state; ALUop defaults to 000.
REQ-027 The FSM SHALL latch opcode internally at the DECODE edge, so that MEM_ADDR, I_EXEC and BRANCH do not depend on later changes of the opcode input.
REQ-028 Instruction latency excluding memory wait cycles: lw 5, sw 4, R 4, addi/ori 4, beq/bne 3, j 3 cycles.

Reset
REQ-029 While reset=1: state=FETCH; pc_write, ir_write, reg_write, mem_write and illegal_op SHALL be forced to 0.
REQ-030 After reset is released, the first rising edge SHALL evaluate FETCH normally.
REQ-031 Asserting reset in any state, including a wait in MEM_READ or MEM_WRITE, SHALL abort the instruction with no further write-enable pulse.

Verification
REQ-032 Reset, then opcode=000000 with mem_ready=1: state sequence 0,1,6,7,0; ALUop=111 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB.
REQ-033 lw (100011) with mem_ready=0 for 3 cycles in MEM_READ: state 3 held for 4 cycles; reg_write=1 and mem_to_reg=1 in the single MEM_WB cycle.
REQ-034 beq with zero=1: pc_write=1 and pc_source=01 in BRANCH. bne with zero=1: pc_write=0.
REQ-035 Opcode 111111: illegal_op=1 for one cycle in DECODE, next state 0, no write enable asserted.
REQ-036 Reset asserted mid-MEM_WRITE: mem_write drops to 0 and state reads 0 immediately, without waiting for a clock edge.
REQ-037 ori (001101): alu_src_b=11 and ALUop=001 in I_EXEC; reg_write=1 in I_WB; 4 cycles total.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of a multicycle MIPS-style datapath.
// Moore decode from the state register; only write enables see mem_ready, zero and reset.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic            ir_we, pc_we, reg_we, mem_we, illegal;

  // State and latched opcode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d    = S_FETCH;
    opcode_d   = opcode_q;
    ALUop      = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        opcode_d  = opcode;
        case (opcode)
          OP_R:           state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        ALUop     = ALU_RTYPE;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        if (opcode_q == OP_ORI) begin
          alu_src_b = 2'b11;
          ALUop     = ALU_OR;
        end else begin
          alu_src_b = 2'b10;
        end
        state_d = S_I_WB;
      end
      S_I_WB: reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUop     = ALU_SUB;
        pc_source = 2'b01;
        pc_we     = ((opcode_q == OP_BEQ) && zero) || ((opcode_q == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_we     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset kills every write enable combinationally so an abort never leaks a pulse
  assign ir_write   = ir_we & ~reset;
  assign pc_write   = pc_we & ~reset;
  assign reg_write  = reg_we & ~reset;
  assign mem_write  = mem_we & ~reset;
  assign illegal_op = illegal & ~reset;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle compare against a
// per-instruction path model built from the instruction class.
module tb_multicycle_control;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic [2:0] ALUop;
  logic       alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5;
  localparam int R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9, BRANCH = 10, JUMP = 11;

  function automatic logic [16:0] observed();
    return {ALUop, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write, pc_write,
            reg_write, reg_dst, mem_to_reg, pc_source, illegal_op};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101,
                      6'b000100, 6'b000101, 6'b000010};
  endfunction

  // Expected outputs straight from the per-state control table
  function automatic logic [16:0] exp_out(int st, logic [5:0] op, logic mr, logic z);
    logic [2:0] aop; logic sa; logic [1:0] sb, ps;
    logic iod, mrd, mwr, irw, pcw, rw, rd, m2r, ill;
    {aop, sa, sb, iod, mrd, mwr, irw, pcw, rw, rd, m2r, ps, ill} = '0;
    case (st)
      FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      DECODE:    begin sb = 2'b10; ill = !is_legal(op); end
      MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      MEM_READ:  begin mrd = 1; iod = 1; end
      MEM_WB:    begin rw = 1; m2r = 1; end
      MEM_WRITE: begin mwr = 1; iod = 1; end
      R_EXEC:    begin sa = 1; aop = 3'b111; end
      R_WB:      begin rw = 1; rd = 1; end
      I_EXEC:    begin sa = 1; sb = (op == 6'b001101) ? 2'b11 : 2'b10;
                       aop = (op == 6'b001101) ? 3'b001 : 3'b000; end
      I_WB:      rw = 1;
      BRANCH:    begin sa = 1; aop = 3'b101; ps = 2'b01;
                       pcw = (op == 6'b000100) ? z : !z; end
      JUMP:      begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {aop, sa, sb, iod, mrd, mwr, irw, pcw, rw, rd, m2r, ps, ill};
  endfunction

  // Runs one instruction with fw fetch waits and mw data-memory waits, checking every cycle.
  // abort_at >= 0 asserts reset mid-cycle in that path index instead of finishing.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           input int abort_at, input string name);
    int sq[$]; logic mq[$];
    logic [5:0] op_drv; logic mr_drv, z_drv;
    for (int i = 0; i <= fw; i++) begin sq.push_back(FETCH); mq.push_back(i == fw); end
    sq.push_back(DECODE); mq.push_back(1'($urandom));
    case (op)
      6'b000000: begin sq.push_back(R_EXEC); sq.push_back(R_WB); end
      6'b100011: begin
        sq.push_back(MEM_ADDR); mq.push_back(1'($urandom));
        for (int i = 0; i <= mw; i++) begin sq.push_back(MEM_READ); mq.push_back(i == mw); end
        sq.push_back(MEM_WB);
      end
      6'b101011: begin
        sq.push_back(MEM_ADDR); mq.push_back(1'($urandom));
        for (int i = 0; i <= mw; i++) begin sq.push_back(MEM_WRITE); mq.push_back(i == mw); end
      end
      6'b001000, 6'b001101: begin sq.push_back(I_EXEC); sq.push_back(I_WB); end
      6'b000100, 6'b000101: sq.push_back(BRANCH);
      6'b000010: sq.push_back(JUMP);
      default: ;
    endcase
    while (mq.size() < sq.size()) mq.push_back(1'($urandom));
    for (int i = 0; i < sq.size(); i++) begin
      mr_drv = mq[i];
      z_drv  = (sq[i] == BRANCH) ? z : 1'($urandom);
      op_drv = (sq[i] == DECODE) ? op : 6'($urandom);
      mem_ready = mr_drv; zero = z_drv; opcode = op_drv;
      #2;
      n_checks++;
      if (state !== 4'(sq[i])) begin
        n_fail++;
        $display("FAIL %s state step %0d: got %0d expected %0d", name, i, state, sq[i]);
      end
      n_checks++;
      if (observed() !== exp_out(sq[i], op, mr_drv, z_drv)) begin
        n_fail++;
        $display("FAIL %s outputs step %0d (state %0d): got %b expected %b", name, i, sq[i],
                 observed(), exp_out(sq[i], op, mr_drv, z_drv));
      end
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || {pc_write, ir_write, reg_write, mem_write, illegal_op} !== 5'b0) begin
          n_fail++;
          $display("FAIL %s abort: got state %0d we %b expected state 0 we 00000", name, state,
                   {pc_write, ir_write, reg_write, mem_write, illegal_op});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0 || {pc_write, ir_write, reg_write, mem_write, illegal_op} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset: got state %0d we %b expected state 0 we 00000", state,
               {pc_write, ir_write, reg_write, mem_write, illegal_op});
    end
    n_checks++;
    if (mem_read !== 1'b1 || alu_src_b !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_fetch_decode: got mem_read %b alu_src_b %b expected 1 01",
               mem_read, alu_src_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();      run_instr(6'b000000, 1'b0, 0, 0, -1, "rtype");   endtask
  task automatic test_lw_wait();    run_instr(6'b100011, 1'b0, 0, 3, -1, "lw_wait"); endtask
  task automatic test_sw();         run_instr(6'b101011, 1'b0, 1, 2, -1, "sw");      endtask
  task automatic test_ori();        run_instr(6'b001101, 1'b0, 0, 0, -1, "ori");     endtask
  task automatic test_addi();       run_instr(6'b001000, 1'b0, 2, 0, -1, "addi");    endtask
  task automatic test_jump();       run_instr(6'b000010, 1'b0, 0, 0, -1, "jump");    endtask
  task automatic test_illegal();    run_instr(6'b111111, 1'b0, 0, 0, -1, "illegal"); endtask

  task automatic test_branch();
    run_instr(6'b000100, 1'b1, 0, 0, -1, "beq_taken");
    run_instr(6'b000100, 1'b0, 0, 0, -1, "beq_not");
    run_instr(6'b000101, 1'b1, 0, 0, -1, "bne_not");
    run_instr(6'b000101, 1'b0, 0, 0, -1, "bne_taken");
  endtask

  // Abort in MEM_WRITE (path index 4 with no fetch wait) and in a MEM_READ wait
  task automatic test_reset_mid_write();
    run_instr(6'b101011, 1'b0, 0, 3, 4, "abort_sw");
    run_instr(6'b000000, 1'b0, 0, 0, -1, "after_abort_sw");
    run_instr(6'b100011, 1'b0, 0, 3, 5, "abort_lw");
    run_instr(6'b001101, 1'b0, 0, 0, -1, "after_abort_lw");
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101, 6'b000100, 6'b000101, 6'b000010};
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      run_instr(op, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_ori();
    test_addi();
    test_jump();
    test_branch();
    test_illegal();
    test_reset_mid_write();
    test_random();
    mem_ready = 1'b0;
    #2;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL final_state: got %0d expected 0", state);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
